// File: rtl/sim_report_driver.sv
// Status driver for the bench top: queues checkpoint codes, shows each one on
// sim_report for a fixed hold time, and reports done/success with a watchdog.
module sim_report_driver #(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned HOLD_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic        evt_valid,
    output logic        evt_ready,
    input  logic [31:0] evt_code,
    input  logic        evt_fail,
    input  logic        finish,
    output logic [31:0] sim_report,
    output logic        sim_done,
    output logic        sim_success,
    output logic [7:0]  fail_count,
    output logic        busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned HW = $clog2(HOLD_CYCLES) + 1;
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);
    localparam logic          WD_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0]   WD_CODE   = 32'hDEAD_DEAD;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [WW-1:0] wd_q, wd_d;
    logic [31:0]   report_q, report_d;
    logic          done_q, done_d;
    logic          success_q, success_d;
    logic [7:0]    fails_q, fails_d;
    logic          pending_q, pending_d;
    logic [31:0]   mem_q [DEPTH];

    logic full, empty, push, wd_fire;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign evt_ready   = !full && (state_q != DONE);
    assign push        = evt_valid && evt_ready;
    assign wd_fire     = WD_EN && (state_q != DONE) && (wd_q == WD_LAST);
    assign busy        = !empty || (state_q == SHOW);
    assign sim_report  = report_q;
    assign sim_done    = done_q;
    assign sim_success = success_q;
    assign fail_count  = fails_q;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        hold_d    = hold_q;
        wd_d      = wd_q;
        report_d  = report_q;
        done_d    = done_q;
        success_d = success_q;
        fails_d   = fails_q;
        pending_d = pending_q || (finish && state_q != DONE);

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (evt_fail && fails_q != 8'hFF) begin
                fails_d = fails_q + 8'd1;
            end
        end

        if (WD_EN && state_q != DONE) begin
            wd_d = wd_q + WW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    report_d = mem_q[rd_ptr_q[AW-1:0]];
                    hold_d   = HOLD_INIT;
                    state_d  = SHOW;
                end else if (pending_q && !push) begin
                    // a same-cycle push would be lost, so finishing waits for it
                    state_d   = DONE;
                    done_d    = 1'b1;
                    success_d = (fails_q == 8'd0);
                end
            end
            SHOW: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - HW'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            DONE: ;
            default: ;
        endcase

        if (wd_fire) begin
            state_d   = DONE;
            done_d    = 1'b1;
            success_d = 1'b0;
            report_d  = WD_CODE;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            hold_q    <= '0;
            wd_q      <= '0;
            report_q  <= '0;
            done_q    <= 1'b0;
            success_q <= 1'b0;
            fails_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            hold_q    <= hold_d;
            wd_q      <= wd_d;
            report_q  <= report_d;
            done_q    <= done_d;
            success_q <= success_d;
            fails_q   <= fails_d;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge refclk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= evt_code;
        end
    end

endmodule

// File: tb/tb_sim_report_driver.sv
// Directed bench for sim_report_driver: hold timing, FIFO backpressure,
// fail counting, finish ordering, watchdog and mid-run reset.
module tb_sim_report_driver;

    logic        refclk = 1'b0;
    logic        rst;
    logic        evt_valid;
    logic        evt_ready;
    logic [31:0] evt_code;
    logic        evt_fail;
    logic        finish;
    logic [31:0] sim_report;
    logic        sim_done;
    logic        sim_success;
    logic [7:0]  fail_count;
    logic        busy;

    int checks = 0;
    int failures = 0;

    int          acc_n;
    int          nchg;
    bit          acc;
    bit          saw_full;
    logic [31:0] prev;
    logic [31:0] vals [6];
    int          cycs [6];

    sim_report_driver #(
        .DEPTH(4),
        .HOLD_CYCLES(4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_code(evt_code),
        .evt_fail(evt_fail),
        .finish(finish),
        .sim_report(sim_report),
        .sim_done(sim_done),
        .sim_success(sim_success),
        .fail_count(fail_count),
        .busy(busy)
    );

    always #5 refclk = ~refclk;

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        evt_valid = 1'b0;
        evt_fail  = 1'b0;
        finish    = 1'b0;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        evt_valid = 1'b0;
        evt_code  = '0;
        evt_fail  = 1'b0;
        finish    = 1'b0;

        // single event then finish
        do_reset();
        chk("rst_report", sim_report, 32'h0);
        chk("rst_done", 32'(sim_done), 32'h0);
        chk("rst_success", 32'(sim_success), 32'h0);
        chk("rst_fail_count", 32'(fail_count), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ready", 32'(evt_ready), 32'h1);
        evt_valid = 1'b1;
        evt_code  = 32'h1;
        tick();
        evt_valid = 1'b0;
        finish    = 1'b1;
        chk("t1_pre_report", sim_report, 32'h0);
        chk("t1_busy", 32'(busy), 32'h1);
        tick();
        finish = 1'b0;
        chk("t1_show", sim_report, 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_hold", sim_report, 32'h1);
            chk("t1_not_done", 32'(sim_done), 32'h0);
        end
        tick();
        chk("t1_done", 32'(sim_done), 32'h1);
        chk("t1_success", 32'(sim_success), 32'h1);
        chk("t1_fail_count", 32'(fail_count), 32'h0);
        chk("t1_final_report", sim_report, 32'h1);
        chk("t1_ready_off", 32'(evt_ready), 32'h0);

        // burst of six into a four-deep FIFO
        do_reset();
        evt_valid = 1'b1;
        evt_code  = 32'h10;
        acc_n     = 0;
        nchg      = 0;
        saw_full  = 1'b0;
        prev      = sim_report;
        for (int c = 1; c <= 40; c++) begin
            acc = evt_valid && evt_ready;
            if (evt_valid && !evt_ready) saw_full = 1'b1;
            tick();
            if (acc) begin
                acc_n++;
                evt_code = evt_code + 32'h1;
                if (acc_n == 6) evt_valid = 1'b0;
            end
            if (sim_report !== prev) begin
                if (nchg < 6) begin
                    vals[nchg] = sim_report;
                    cycs[nchg] = c;
                end
                nchg++;
                prev = sim_report;
            end
        end
        evt_valid = 1'b0;
        chk("t2_accepted", 32'(acc_n), 32'd6);
        chk("t2_backpressure", 32'(saw_full), 32'h1);
        chk("t2_changes", 32'(nchg), 32'd6);
        for (int i = 0; i < 6 && i < nchg; i++) begin
            chk("t2_order", vals[i], 32'h10 + 32'(i));
            if (i > 0) chk("t2_interval", 32'(cycs[i] - cycs[i-1]), 32'd5);
        end
        chk("t2_first_at", 32'(cycs[0]), 32'd2);

        // one failing event, one passing, then finish
        do_reset();
        evt_valid = 1'b1;
        evt_code  = 32'h20;
        evt_fail  = 1'b1;
        tick();
        evt_code  = 32'h21;
        evt_fail  = 1'b0;
        tick();
        evt_valid = 1'b0;
        finish    = 1'b1;
        tick();
        finish = 1'b0;
        chk("t3_fail_count", 32'(fail_count), 32'h1);
        for (int c = 0; c < 30 && !sim_done; c++) tick();
        chk("t3_done", 32'(sim_done), 32'h1);
        chk("t3_success", 32'(sim_success), 32'h0);
        chk("t3_report", sim_report, 32'h21);
        chk("t3_fail_final", 32'(fail_count), 32'h1);

        // finish on the same edge as an accept
        do_reset();
        evt_valid = 1'b1;
        evt_code  = 32'hAA;
        finish    = 1'b1;
        tick();
        evt_valid = 1'b0;
        finish    = 1'b0;
        tick();
        chk("t4_show", sim_report, 32'hAA);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_hold", sim_report, 32'hAA);
            chk("t4_not_done", 32'(sim_done), 32'h0);
        end
        tick();
        chk("t4_done", 32'(sim_done), 32'h1);
        chk("t4_success", 32'(sim_success), 32'h1);
        chk("t4_ready_off", 32'(evt_ready), 32'h0);
        evt_valid = 1'b1;
        evt_code  = 32'hBB;
        evt_fail  = 1'b1;
        tick();
        tick();
        evt_valid = 1'b0;
        evt_fail  = 1'b0;
        chk("t4_ignored_report", sim_report, 32'hAA);
        chk("t4_ignored_fail", 32'(fail_count), 32'h0);
        chk("t4_ignored_busy", 32'(busy), 32'h0);

        // watchdog with an event queued just before expiry
        do_reset();
        for (int i = 0; i < 97; i++) tick();
        chk("t5_not_yet", 32'(sim_done), 32'h0);
        evt_valid = 1'b1;
        evt_code  = 32'h55;
        tick();
        evt_valid = 1'b0;
        chk("t5_queued", 32'(busy), 32'h1);
        tick();
        chk("t5_show", sim_report, 32'h55);
        chk("t5_not_done", 32'(sim_done), 32'h0);
        tick();
        chk("t5_done", 32'(sim_done), 32'h1);
        chk("t5_success", 32'(sim_success), 32'h0);
        chk("t5_report", sim_report, 32'hDEAD_DEAD);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_ready", 32'(evt_ready), 32'h0);

        // reset while showing with three queued
        do_reset();
        evt_valid = 1'b1;
        evt_code  = 32'h30;
        tick();
        evt_code  = 32'h31;
        evt_fail  = 1'b1;
        tick();
        evt_code  = 32'h32;
        evt_fail  = 1'b0;
        tick();
        evt_code  = 32'h33;
        tick();
        evt_valid = 1'b0;
        chk("t6_showing", sim_report, 32'h30);
        chk("t6_busy", 32'(busy), 32'h1);
        chk("t6_fails", 32'(fail_count), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_report", sim_report, 32'h0);
        chk("t6_rst_done", 32'(sim_done), 32'h0);
        chk("t6_rst_success", 32'(sim_success), 32'h0);
        chk("t6_rst_fails", 32'(fail_count), 32'h0);
        chk("t6_rst_busy", 32'(busy), 32'h0);
        chk("t6_rst_ready", 32'(evt_ready), 32'h1);
        evt_valid = 1'b1;
        evt_code  = 32'h40;
        tick();
        evt_valid = 1'b0;
        tick();
        chk("t6_new_event", sim_report, 32'h40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
